// File: rtl/and_rr_arbiter_pkg.sv
// and_arb_pkg: shared FSM state type, id-width helper and statistics width for the AND arbiter
package and_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, EXEC, DONE} arb_state_e;
  localparam int STATS_W = 16;
  function automatic int idw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/and_rr_arbiter_if.sv
// and_rr_arbiter_if: requester/result bundle of the AND arbiter; outopcnt exists only with AND_ARB_STATS_EN
interface and_rr_arbiter_if #(parameter int NREQ = 4, parameter int W = 1);
  localparam int IDW = and_arb_pkg::idw_f(NREQ);
  logic [NREQ-1:0] inreq;
  logic [NREQ*W-1:0] ina;
  logic [NREQ*W-1:0] inb;
  logic [NREQ-1:0] outgnt;
  logic outen;
  logic outvalid;
  logic [W-1:0] outy;
  logic [IDW-1:0] outid;
  logic outbusy;
`ifdef AND_ARB_STATS_EN
  logic [and_arb_pkg::STATS_W-1:0] outopcnt;
`endif
  modport master (
    output inreq, ina, inb,
    input outgnt, outen, outvalid, outy, outid, outbusy
`ifdef AND_ARB_STATS_EN
    , input outopcnt
`endif
  );
  modport slave (
    input inreq, ina, inb,
    output outgnt, outen, outvalid, outy, outid, outbusy
`ifdef AND_ARB_STATS_EN
    , output outopcnt
`endif
  );
endinterface

// File: rtl/and_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting one past ptr, wrapping modulo NREQ
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);
  logic [IDW-1:0] c;
  // walk from the farthest candidate to the nearest so the nearest requester overwrites the rest
  always_comb begin
    any = |req;
    idx = '0;
    c = '0;
    for (int i = NREQ; i >= 1; i--) begin
      c = IDW'((int'(ptr) + i) % NREQ);
      if (req[c]) idx = c;
    end
  end
endmodule

// File: rtl/and_rr_arbiter.sv
// and_rr_arbiter: round-robin sequencer sharing one registered AND unit; AND_ARB_STATS_EN adds an op counter
module and_rr_arbiter
  import and_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W = 1
) (
  input logic inclk,
  input logic inrst_n,
  and_rr_arbiter_if.slave bus
);
  localparam int IDW = idw_f(NREQ);
  arb_state_e st;
  logic [IDW-1:0] ptr, win, pick;
  logic any;
  logic [W-1:0] opa, opb, res;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req(bus.inreq),
    .ptr(ptr),
    .any(any),
    .idx(pick)
  );

  // sequencer: outputs are registered from the current state, so each pulse lags its state by one edge
  always_ff @(posedge inclk or negedge inrst_n) begin
    if (!inrst_n) begin
      st <= IDLE;
      ptr <= IDW'(NREQ - 1);
      win <= '0;
      opa <= '0;
      opb <= '0;
      res <= '0;
      bus.outgnt <= '0;
      bus.outen <= 1'b0;
      bus.outvalid <= 1'b0;
      bus.outy <= '0;
      bus.outid <= '0;
      bus.outbusy <= 1'b0;
    end else begin
      bus.outgnt <= (st == GRANT) ? NREQ'(1) << win : '0;
      bus.outen <= st == EXEC;
      bus.outvalid <= st == DONE;
      bus.outbusy <= (st == IDLE) ? any : st != DONE;
      case (st)
        IDLE: if (any) begin
          win <= pick;
          st <= GRANT;
        end
        GRANT: begin
          opa <= bus.ina[win*W +: W];
          opb <= bus.inb[win*W +: W];
          st <= EXEC;
        end
        EXEC: begin
          res <= opa & opb;
          st <= DONE;
        end
        default: begin
          bus.outy <= res;
          bus.outid <= win;
          ptr <= win;
          st <= IDLE;
        end
      endcase
    end
  end

`ifdef AND_ARB_STATS_EN
  logic [STATS_W-1:0] opcnt;
  assign bus.outopcnt = opcnt;
  // saturating count of completed operations, bumped on the edge that raises outvalid
  always_ff @(posedge inclk or negedge inrst_n) begin
    if (!inrst_n) opcnt <= '0;
    else if (st == DONE && opcnt != '1) opcnt <= opcnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_and_rr_arbiter.sv
// tb_and_rr_arbiter: table vectors, corner sequences and a randomized reference-model run for and_rr_arbiter
module tb_and_rr_arbiter;
  localparam int NREQ = 4;
  localparam int W = 1;
  logic inclk = 1'b0;
  logic inrst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  and_rr_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
  and_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (.inclk(inclk), .inrst_n(inrst_n), .bus(bus));

  always #5 inclk = ~inclk;

  // unused requesters must never present X
  always @(posedge inclk) if (inrst_n) assert (!$isunknown(bus.inreq)) else $error("FAIL x_on_req: inreq=%b", bus.inreq);

  typedef struct {
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] gnt;
    logic       y;
    int         id;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic do_reset();
    inrst_n = 1'b0;
    bus.inreq = '0;
    tick();
    tick();
    inrst_n = 1'b1;
  endtask

  // one full operation from a table record, starting with the DUT idle
  task automatic run_vec(input vec_t v, input string nm);
    bus.inreq = v.req;
    bus.ina = v.a;
    bus.inb = v.b;
    tick();
    chk({nm, "_busy"}, 32'(bus.outbusy), 1);
    tick();
    chk({nm, "_gnt"}, 32'(bus.outgnt), 32'(v.gnt));
    bus.inreq = '0;
    tick();
    chk({nm, "_en"}, 32'(bus.outen), 1);
    tick();
    chk({nm, "_valid"}, 32'(bus.outvalid), 1);
    chk({nm, "_y"}, 32'(bus.outy), 32'(v.y));
    chk({nm, "_id"}, 32'(bus.outid), 32'(v.id));
    chk({nm, "_idle"}, 32'(bus.outbusy), 0);
  endtask

  function automatic int rr(input int p, input logic [3:0] rq);
    for (int k = 1; k <= NREQ; k++) if (rq[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  initial begin
    bus.inreq = '0;
    bus.ina = '0;
    bus.inb = '0;
    tbl[0] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2};
    tbl[1] = '{4'b1001, 4'b1001, 4'b0001, 4'b1000, 1'b0, 3};
    tbl[2] = '{4'b1001, 4'b1001, 4'b0001, 4'b0001, 1'b1, 0};
    tbl[3] = '{4'b1001, 4'b1000, 4'b1000, 4'b1000, 1'b1, 3};
    tbl[4] = '{4'b0110, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1};
    tbl[5] = '{4'b0110, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2};
    tbl[6] = '{4'b1111, 4'b1111, 4'b1000, 4'b1000, 1'b1, 3};
    tbl[7] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b0, 1};

    // reset held with every requester active: nothing may move
    bus.inreq = 4'b1111;
    bus.ina = 4'b1111;
    bus.inb = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_gnt", 32'(bus.outgnt), 0);
      chk("rst_busy", 32'(bus.outbusy), 0);
      chk("rst_valid", 32'(bus.outvalid), 0);
    end
    chk("rst_en", 32'(bus.outen), 0);
    chk("rst_y", 32'(bus.outy), 0);
    chk("rst_id", 32'(bus.outid), 0);
    inrst_n = 1'b1;
    tick();
    tick();
    chk("first_gnt", 32'(bus.outgnt), 32'b0001);
    bus.inreq = '0;
    tick();
    tick();
    chk("first_valid", 32'(bus.outvalid), 1);
    chk("first_id", 32'(bus.outid), 0);

    // table: single, wrap and contended requests from a fresh pointer
    do_reset();
    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // all requesters held high: strict rotation, one result every 4 cycles
    do_reset();
    begin
      int k;
      int ids[5];
      logic ys[5];
      ids = '{0, 1, 2, 3, 0};
      ys = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      k = 0;
      bus.inreq = 4'b1111;
      bus.ina = 4'b1111;
      bus.inb = 4'b0101;
      for (int c = 1; c <= 21; c++) begin
        tick();
        if (bus.outvalid && k < 5) begin
          chk("rot_id", 32'(bus.outid), 32'(ids[k]));
          chk("rot_cycle", 32'(c), 32'(4 * (k + 1)));
          chk("rot_y", 32'(bus.outy), 32'(ys[k]));
          k++;
        end
      end
      chk("rot_count", 32'(k), 5);
    end

    // reset in EXEC drops the operation; the still-pending requester wins again afterwards
    do_reset();
    bus.inreq = 4'b0010;
    bus.ina = 4'b0010;
    bus.inb = 4'b0010;
    tick();
    tick();
    chk("mid_gnt", 32'(bus.outgnt), 32'b0010);
    inrst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.outbusy), 0);
    chk("mid_gnt_clr", 32'(bus.outgnt), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_novalid", 32'(bus.outvalid), 0);
    end
    inrst_n = 1'b1;
    tick();
    tick();
    chk("mid_regnt", 32'(bus.outgnt), 32'b0010);
    bus.inreq = '0;
    tick();
    tick();
    chk("mid_valid", 32'(bus.outvalid), 1);
    chk("mid_id", 32'(bus.outid), 1);

`ifdef AND_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) run_vec(tbl[0], "stat");
    chk("opcnt5", 32'(bus.outopcnt), 5);
    force dut.opcnt = 16'hFFFE;
    #2;
    release dut.opcnt;
    for (int i = 0; i < 3; i++) run_vec(tbl[0], "sat");
    chk("opcnt_sat", 32'(bus.outopcnt), 32'hFFFF);
`endif

    // randomized requesters against a transaction-level model
    do_reset();
    begin
      int s, n, win, mptr, eid;
      logic ca, cb, ey;
      logic [3:0] egnt;
      s = -100;
      n = 0;
      win = 0;
      mptr = NREQ - 1;
      eid = 0;
      ey = 1'b0;
      ca = 1'b0;
      cb = 1'b0;
      egnt = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
        for (int r = 0; r < NREQ; r++) begin
          if (egnt[r]) bus.inreq[r] = 1'b0;
          else if (!bus.inreq[r] && $urandom_range(3) == 0) begin
            bus.inreq[r] = 1'b1;
            bus.ina[r] = 1'($urandom_range(1));
            bus.inb[r] = 1'($urandom_range(1));
          end
        end
        n++;
        if (n >= s + 4 && |bus.inreq) begin
          s = n;
          win = rr(mptr, bus.inreq);
        end
        if (n == s + 1) begin
          ca = bus.ina[win];
          cb = bus.inb[win];
        end
        if (n == s + 3) begin
          ey = ca & cb;
          eid = win;
          mptr = win;
        end
        egnt = (n == s + 1) ? 4'(1 << win) : 4'b0000;
        tick();
        chk("rnd_gnt", 32'(bus.outgnt), 32'(egnt));
        chk("rnd_en", 32'(bus.outen), 32'(n == s + 2));
        chk("rnd_valid", 32'(bus.outvalid), 32'(n == s + 3));
        chk("rnd_busy", 32'(bus.outbusy), 32'(n >= s && n <= s + 2));
        chk("rnd_y", 32'(bus.outy), 32'(ey));
        chk("rnd_id", 32'(bus.outid), 32'(eid));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
